ps2_kbd_ctrl: RTL
=================

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, SHALL set the clk cycles allowed between a prefix byte and its follow-on byte.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two, SHALL set the key-event buffer depth.
REQ-003 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high permits reception.
REQ-006 byte_data  input  8  byte from the PS/2 receiver.
REQ-007 full_byte_received  input  1  one-cycle strobe; byte_data is valid in that cycle.
REQ-008 wait_for_data  output  1  level that arms the receiver's wait state.
REQ-009 start_receiving_data  output  1  one-cycle pulse that re-arms the receiver after each byte.
REQ-010 evt_valid  output  1  FIFO non-empty.
REQ-011 evt_ready  input  1  consumer pops the head entry when evt_valid and evt_ready are both high.
REQ-012 evt_data  output  10  head event: {ext, brk, code[7:0]}.
REQ-013 overflow  output  1  sticky flag; cleared only by reset.

Function
REQ-014 wait_for_data SHALL equal enable AND NOT fifo_full, registered, with 1-cycle latency.
REQ-015 start_receiving_data SHALL pulse in the cycle after each accepted full_byte_received.
REQ-016 Strobes arriving while enable=0 SHALL be ignored, with no state change.
REQ-017 Decoder FSM states: IDLE, EXT (seen E0), BRK (seen F0), EXT_BRK (seen E0 F0).
REQ-018 IDLE: E0 -> EXT; F0 -> BRK; any other byte -> push {0,0,byte}, stay IDLE.
REQ-019 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> push {1,0,byte}, go IDLE.
REQ-020 BRK: other -> push {0,1,byte}, go IDLE; E0 or F0 -> discard prefix, go IDLE, byte ignored.
REQ-021 EXT_BRK: other -> push {1,1,byte}, go IDLE; E0 or F0 -> go IDLE, byte ignored.
REQ-022 Timeout counter SHALL reset on every accepted byte and run only in non-IDLE states.
REQ-023 On reaching TIMEOUT_CYCLES, the FSM SHALL return to IDLE and push no event.
REQ-024 An event is pushed 1 cycle after its strobe; evt_valid SHALL rise 1 cycle after the push; the FIFO is first-word-fall-through.
REQ-025 A push while full (strobe already in flight) SHALL drop the event and set overflow; FIFO contents are kept.
REQ-026 A simultaneous push and pop while full SHALL succeed with no overflow.
REQ-027 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full/empty SHALL be derived from the MSB compare.
REQ-028 Deasserting enable mid-sequence SHALL keep FSM state; the timeout still applies.

Reset
REQ-029 On rst=0, asynchronously: FSM=IDLE, counter=0, FIFO empty, wait_for_data=0, start_receiving_data=0, evt_valid=0, evt_data=0, overflow=0.
REQ-030 After reset release, wait_for_data SHALL rise on the first clk edge with enable=1.

Structure
REQ-031 Shared package ps2_pkg SHALL hold PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0, EVT_W=10, and the FSM state encoding.
REQ-032 The FIFO SHALL be sub-module ps2_event_fifo (params WIDTH, DEPTH); the FSM and timeout SHALL live in ps2_kbd_ctrl.

Verification
REQ-033 Strobe 5A, evt_ready=1 -> one event 0x05A, start_receiving_data pulse after the strobe.
REQ-034 Strobes F0, 5A -> one event 0x15A; no event after F0 alone.
REQ-035 Strobes E0, F0, 75 -> one event 0x375; E0, 75 -> 0x275.
REQ-036 Strobe E0, then idle TIMEOUT_CYCLES, then 1C -> event 0x01C only.
REQ-037 evt_ready=0, 5 single-byte strobes (depth 4) -> wait_for_data low after the 4th push, 5th dropped, overflow=1, pop order preserved.
REQ-038 rst asserted after F0 -> all outputs zero immediately; next 5A -> 0x05A.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and decoder state encoding for the PS/2 keyboard controller.
// Events are packed as {ext, brk, code[7:0]}.
package ps2_pkg;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;
    localparam int         EVT_W      = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    function automatic logic [EVT_W-1:0] make_evt(input logic ext, input logic brk,
                                                   input logic [7:0] code);
        return {ext, brk, code};
    endfunction

    function automatic logic is_prefix(input logic [7:0] code);
        return (code == PREFIX_EXT) || (code == PREFIX_BRK);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through key-event FIFO with a sticky overflow flag.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int WIDTH = EVT_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_en;
    logic             wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || rd_en);

    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into {ext, brk, code} events
// with a prefix timeout, and buffers events for a ready/valid consumer.
//
// state      | meaning
// -----------+------------------------------------------
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen, waiting for code or F0
// ST_BRK     | F0 seen, waiting for code
// ST_EXT_BRK | E0 F0 seen, waiting for code
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [7:0]       byte_data,
    input  logic             full_byte_received,
    output logic             wait_for_data,
    output logic             start_receiving_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [EVT_W-1:0] evt_data,
    output logic             overflow
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYCLES - 1);

    kbd_state_t       state;
    logic [CW-1:0]    to_cnt;
    logic             push_q;
    logic [EVT_W-1:0] push_data_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;

    assign accept    = full_byte_received && enable;
    assign evt_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= ST_IDLE;
            to_cnt               <= '0;
            push_q               <= 1'b0;
            push_data_q          <= '0;
            start_receiving_data <= 1'b0;
            wait_for_data        <= 1'b0;
        end else begin
            push_q               <= 1'b0;
            start_receiving_data <= accept;
            wait_for_data        <= enable && !fifo_full;

            if (accept) begin
                // Reloaded on every byte; cleared again below when the byte ends a sequence.
                to_cnt <= TO_LOAD;
                case (state)
                    ST_IDLE: begin
                        if (byte_data == PREFIX_EXT) begin
                            state <= ST_EXT;
                        end else if (byte_data == PREFIX_BRK) begin
                            state <= ST_BRK;
                        end else begin
                            push_q      <= 1'b1;
                            push_data_q <= make_evt(1'b0, 1'b0, byte_data);
                            to_cnt      <= '0;
                        end
                    end
                    ST_EXT: begin
                        if (byte_data == PREFIX_BRK) begin
                            state <= ST_EXT_BRK;
                        end else if (byte_data != PREFIX_EXT) begin
                            push_q      <= 1'b1;
                            push_data_q <= make_evt(1'b1, 1'b0, byte_data);
                            state       <= ST_IDLE;
                            to_cnt      <= '0;
                        end
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        // A prefix where a code is expected abandons the whole sequence.
                        if (!is_prefix(byte_data)) begin
                            push_q      <= 1'b1;
                            push_data_q <= make_evt(state == ST_EXT_BRK, 1'b1, byte_data);
                        end
                        state  <= ST_IDLE;
                        to_cnt <= '0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        to_cnt <= '0;
                    end
                endcase
            end else if (state != ST_IDLE) begin
                if (to_cnt == '0) begin
                    state <= ST_IDLE;
                end else begin
                    to_cnt <= to_cnt - 1'b1;
                end
            end
        end
    end

    ps2_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (evt_ready),
        .pop_data  (evt_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

endmodule
